kernel_channel_pe_array: RTL and testbench



---
 rtl/kernel_channel_pe_array.sv | 194 +++++++++++++++++++
 tb/tb_kernel_channel_pe_array.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_channel_pe_array.sv
// NUM_CHANNEL x NUM_KERNEL signed MAC array with a runtime accumulation length and saturating per-kernel psums.
// Define KCPE_ERR_MON_EN to build the sticky error monitor on err_psum_val; otherwise that port is tied to 0.
module kernel_channel_pe_array #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int PSUM_WIDTH  = 24,
    parameter int CNT_WIDTH   = 8,
    parameter int REG_WIDTH   = 32
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]            i_data,
    input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight,
    input  logic [PSUM_WIDTH*NUM_KERNEL-1:0]            i_psum,
    input  logic                                        i_psum_use,
    input  logic [CNT_WIDTH-1:0]                        i_acc_len,
    input  logic                                        i_val,
    output logic                                        o_rdy,
    output logic [PSUM_WIDTH*NUM_KERNEL-1:0]            o_psum,
    output logic                                        o_psum_val,
    input  logic                                        i_psum_rdy,
    output logic                                        o_busy,
    output logic [REG_WIDTH-1:0]                        err_psum_val
);

    localparam int NUM_PE = NUM_CHANNEL * NUM_KERNEL;
    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(NUM_CHANNEL + 1);
    localparam int EXT_W  = ((PSUM_WIDTH > SUM_W) ? PSUM_WIDTH : SUM_W) + 2;
    localparam logic signed [EXT_W-1:0] PSUM_MAX = {{(EXT_W-PSUM_WIDTH+1){1'b0}}, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] PSUM_MIN = {{(EXT_W-PSUM_WIDTH+1){1'b1}}, {(PSUM_WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic                           stall;
    logic                           first;
    logic [1:0]                     state;
    logic [CNT_WIDTH-1:0]           acc_len;
    logic [CNT_WIDTH-1:0]           cnt;
    logic [CNT_WIDTH-1:0]           cnt_inc;
    logic [CNT_WIDTH-1:0]           len_eff;
    logic                           m_val;
    logic                           m_psum_use;
    logic [CNT_WIDTH-1:0]           m_acc_len;
    logic [PSUM_WIDTH*NUM_KERNEL-1:0] m_psum;
    logic signed [PROD_W-1:0]       prod_d [NUM_PE];
    logic signed [PROD_W-1:0]       m_prod [NUM_PE];
    logic signed [EXT_W-1:0]        raw [NUM_KERNEL];
    logic signed [PSUM_WIDTH-1:0]   acc [NUM_KERNEL];
    logic signed [PSUM_WIDTH-1:0]   acc_next [NUM_KERNEL];

    assign stall   = o_psum_val && !i_psum_rdy;
    assign o_rdy   = rst_n && !stall;
    assign first   = (state != ST_ACC);
    assign cnt_inc = cnt + 1'b1;
    assign len_eff = (m_acc_len == '0) ? CNT_WIDTH'(1) : m_acc_len;
    assign o_busy  = (state != ST_IDLE) || m_val || o_psum_val;

    always_comb begin
        for (int p = 0; p < NUM_PE; p++) begin
            prod_d[p] = PROD_W'($signed(i_weight[p*BIT_WIDTH +: BIT_WIDTH]))
                      * PROD_W'($signed(i_data[(p % NUM_CHANNEL)*BIT_WIDTH +: BIT_WIDTH]));
        end
    end

    // A DONE cycle counts as "first" so a beat arriving then starts the next window without a bubble.
    always_comb begin
        for (int k = 0; k < NUM_KERNEL; k++) begin
            logic signed [SUM_W-1:0] s;
            logic signed [EXT_W-1:0] r;
            s = '0;
            for (int c = 0; c < NUM_CHANNEL; c++) begin
                s = s + SUM_W'(m_prod[k*NUM_CHANNEL + c]);
            end
            if (first) begin
                r = m_psum_use ? EXT_W'($signed(m_psum[k*PSUM_WIDTH +: PSUM_WIDTH])) : '0;
            end else begin
                r = EXT_W'(acc[k]);
            end
            r      = r + EXT_W'(s);
            raw[k] = r;
            if (r > PSUM_MAX) begin
                acc_next[k] = PSUM_MAX[PSUM_WIDTH-1:0];
            end else if (r < PSUM_MIN) begin
                acc_next[k] = PSUM_MIN[PSUM_WIDTH-1:0];
            end else begin
                acc_next[k] = r[PSUM_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val      <= 1'b0;
            m_psum_use <= 1'b0;
            m_acc_len  <= '0;
            m_psum     <= '0;
            for (int p = 0; p < NUM_PE; p++) begin
                m_prod[p] <= '0;
            end
        end else if (!stall) begin
            m_val <= i_val;
            if (i_val) begin
                m_psum_use <= i_psum_use;
                m_acc_len  <= i_acc_len;
                m_psum     <= i_psum;
                for (int p = 0; p < NUM_PE; p++) begin
                    m_prod[p] <= prod_d[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc_len <= '0;
            cnt     <= '0;
            for (int k = 0; k < NUM_KERNEL; k++) begin
                acc[k] <= '0;
            end
        end else if (!stall) begin
            if (m_val) begin
                for (int k = 0; k < NUM_KERNEL; k++) begin
                    acc[k] <= acc_next[k];
                end
                if (first) begin
                    acc_len <= len_eff;
                    cnt     <= CNT_WIDTH'(1);
                    state   <= (len_eff == CNT_WIDTH'(1)) ? ST_DONE : ST_ACC;
                end else begin
                    cnt   <= cnt_inc;
                    state <= (cnt_inc == acc_len) ? ST_DONE : ST_ACC;
                end
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_psum_val <= 1'b0;
            o_psum     <= '0;
        end else if (!stall) begin
            o_psum_val <= (state == ST_DONE);
            if (state == ST_DONE) begin
                for (int k = 0; k < NUM_KERNEL; k++) begin
                    o_psum[k*PSUM_WIDTH +: PSUM_WIDTH] <= acc[k];
                end
            end
        end
    end

`ifdef KCPE_ERR_MON_EN
    logic [3:0] err_flags;
    logic       sat_any;
    logic       stall_q;
    logic       i_val_q;

    always_comb begin
        sat_any = 1'b0;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            if ((raw[k] > PSUM_MAX) || (raw[k] < PSUM_MIN)) begin
                sat_any = 1'b1;
            end
        end
    end

    // A pending beat withdrawn during backpressure is flagged; gaps after an accepted beat are legal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags <= '0;
            stall_q   <= 1'b0;
            i_val_q   <= 1'b0;
        end else begin
            stall_q <= stall;
            i_val_q <= i_val;
            if (!stall && m_val && first && (m_acc_len == '0)) err_flags[0] <= 1'b1;
            if (!stall && m_val && sat_any)                    err_flags[1] <= 1'b1;
            if (!stall && m_val && !first && m_psum_use)       err_flags[2] <= 1'b1;
            if (stall && stall_q && i_val_q && !i_val)         err_flags[3] <= 1'b1;
        end
    end

    assign err_psum_val = REG_WIDTH'(err_flags);
`else
    assign err_psum_val = '0;
`endif

endmodule

// File: tb/tb_kernel_channel_pe_array.sv
// Randomised and directed bench for kernel_channel_pe_array, checked against a transaction-level psum model.
// The model tracks error flags too, so the bench also works with KCPE_ERR_MON_EN defined.
module tb_kernel_channel_pe_array;

    localparam int BW = 8;
    localparam int NC = 3;
    localparam int NK = 4;
    localparam int PW = 24;
    localparam int CW = 8;
    localparam int RW = 32;
    localparam int DW = BW * NC;
    localparam int WW = BW * NC * NK;
    localparam int OW = PW * NK;
    localparam longint PMAX = (longint'(1) <<< (PW - 1)) - 1;
    localparam longint PMIN = -(longint'(1) <<< (PW - 1));

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] i_data;
    logic [WW-1:0] i_weight;
    logic [OW-1:0] i_psum;
    logic          i_psum_use;
    logic [CW-1:0] i_acc_len;
    logic          i_val;
    logic          o_rdy;
    logic [OW-1:0] o_psum;
    logic          o_psum_val;
    logic          i_psum_rdy;
    logic          o_busy;
    logic [RW-1:0] err_psum_val;

    int vectors      = 0;
    int miscompares  = 0;
    int cycle        = 0;
    int resultsSeen  = 0;
    int lastAccCycle = 0;
    bit randRdy      = 1'b0;

    logic [OW-1:0] expQ[$];
    bit            mActive   = 1'b0;
    int            mLen      = 0;
    int            mCnt      = 0;
    longint        mAcc[NK];
    logic [3:0]    expErr    = '0;
    bit            prevStall = 1'b0;
    bit            prevIval  = 1'b0;

    kernel_channel_pe_array #(
        .BIT_WIDTH(BW), .NUM_CHANNEL(NC), .NUM_KERNEL(NK),
        .PSUM_WIDTH(PW), .CNT_WIDTH(CW), .REG_WIDTH(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_weight(i_weight),
        .i_psum(i_psum), .i_psum_use(i_psum_use), .i_acc_len(i_acc_len),
        .i_val(i_val), .o_rdy(o_rdy), .o_psum(o_psum), .o_psum_val(o_psum_val),
        .i_psum_rdy(i_psum_rdy), .o_busy(o_busy), .err_psum_val(err_psum_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        if (randRdy) begin
            #1;
            i_psum_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [DW-1:0] packData(input int a, input int b, input int c);
        return {BW'(c), BW'(b), BW'(a)};
    endfunction

    function automatic logic [WW-1:0] weightAll(input int v);
        logic [WW-1:0] w;
        for (int p = 0; p < NC * NK; p++) w[p*BW +: BW] = BW'(v);
        return w;
    endfunction

    function automatic logic [WW-1:0] weightKplus1();
        logic [WW-1:0] w;
        for (int k = 0; k < NK; k++)
            for (int c = 0; c < NC; c++) w[(k*NC+c)*BW +: BW] = BW'(k + 1);
        return w;
    endfunction

    function automatic logic [OW-1:0] lit4(input int a, input int b, input int c, input int d);
        return {PW'(d), PW'(c), PW'(b), PW'(a)};
    endfunction

    function automatic longint dotK(input logic [DW-1:0] d, input logic [WW-1:0] w, input int k);
        longint s = 0;
        for (int c = 0; c < NC; c++) begin
            logic signed [BW-1:0] dv;
            logic signed [BW-1:0] wv;
            dv = d[c*BW +: BW];
            wv = w[(k*NC+c)*BW +: BW];
            s += longint'(dv) * longint'(wv);
        end
        return s;
    endfunction

    // Transaction-level reference: one accepted beat updates the running window sums.
    task automatic modelBeat();
        longint        r;
        logic [OW-1:0] pk;
        if (!mActive) begin
            mActive = 1'b1;
            mCnt    = 0;
            mLen    = (i_acc_len == 0) ? 1 : int'(i_acc_len);
            if (i_acc_len == 0) expErr[0] = 1'b1;
            for (int k = 0; k < NK; k++) begin
                logic signed [PW-1:0] sv;
                sv      = i_psum[k*PW +: PW];
                mAcc[k] = i_psum_use ? longint'(sv) : 0;
            end
        end else if (i_psum_use) begin
            expErr[2] = 1'b1;
        end
        for (int k = 0; k < NK; k++) begin
            r = mAcc[k] + dotK(i_data, i_weight, k);
            if (r > PMAX || r < PMIN) expErr[1] = 1'b1;
            mAcc[k] = (r > PMAX) ? PMAX : ((r < PMIN) ? PMIN : r);
        end
        mCnt++;
        if (mCnt == mLen) begin
            pk = '0;
            for (int k = 0; k < NK; k++) pk[k*PW +: PW] = mAcc[k][PW-1:0];
            expQ.push_back(pk);
            mActive = 1'b0;
        end
    endtask

    // Per-cycle compare of handshake and result against the model, then feed the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            bit stallNow;
            stallNow = o_psum_val && !i_psum_rdy;
            checkOutput("rdy_vs_stall", o_rdy, !stallNow);
            if (o_psum_val) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid", o_psum_val, 1'b0);
                end else begin
                    checkOutput("psum_model", o_psum, expQ[0]);
                    if (i_psum_rdy) begin
                        void'(expQ.pop_front());
                        resultsSeen++;
                    end
                end
            end
            if (stallNow && prevStall && prevIval && !i_val) expErr[3] = 1'b1;
            prevStall = stallNow;
            prevIval  = i_val;
            if (i_val && o_rdy) modelBeat();
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] d, input logic [WW-1:0] w, input logic [OW-1:0] p,
                                 input logic useP, input logic [CW-1:0] len);
        int guard = 0;
        bit took  = 1'b0;
        i_data = d; i_weight = w; i_psum = p; i_psum_use = useP; i_acc_len = len; i_val = 1'b1;
        do begin
            @(negedge clk);
            took = o_rdy;
            @(posedge clk);
            #1;
            guard++;
        end while (!took && guard < 200);
        checkOutput("beat_accepted", took, 1'b1);
        lastAccCycle = cycle;
        i_val = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        i_val = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitResult(input string name, input logic [OW-1:0] exp, input bit checkLat);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!o_psum_val && g < 100);
        checkOutput({name, "_seen"}, o_psum_val, 1'b1);
        checkOutput({name, "_value"}, o_psum, exp);
        if (checkLat) checkOutput({name, "_latency"}, cycle - lastAccCycle + 1, 3);
        @(posedge clk);
        #1;
    endtask

    task automatic drainCheck(input string name);
        int g = 0;
        i_val = 1'b0;
        if (!randRdy) i_psum_rdy = 1'b1;
        do begin
            @(negedge clk);
            g++;
        end while (o_busy && g < 100);
        checkOutput({name, "_idle"}, o_busy, 1'b0);
        checkOutput({name, "_queue_empty"}, expQ.size(), 0);
`ifdef KCPE_ERR_MON_EN
        checkOutput({name, "_err"}, err_psum_val, RW'(expErr));
`else
        checkOutput({name, "_err"}, err_psum_val, 0);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int hold);
        rst_n = 1'b0;
        #1;
        expQ.delete();
        mActive = 1'b0; expErr = '0; prevStall = 1'b0; prevIval = 1'b0;
        checkOutput("reset_valid", o_psum_val, 1'b0);
        checkOutput("reset_psum", o_psum, 0);
        checkOutput("reset_busy", o_busy, 1'b0);
        checkOutput("reset_err", err_psum_val, 0);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_rdy", o_rdy, 1'b1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] randSeed();
        logic [OW-1:0] p;
        for (int k = 0; k < NK; k++) begin
            longint v;
            case ($urandom_range(0, 2))
                0:       v = longint'($urandom_range(0, 2000)) - 1000;
                1:       v = PMAX - longint'($urandom_range(0, 60000));
                default: v = PMIN + longint'($urandom_range(0, 60000));
            endcase
            p[k*PW +: PW] = v[PW-1:0];
        end
        return p;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r0;
        logic [OW-1:0] held;
        rst_n = 1'b1; i_data = '0; i_weight = '0; i_psum = '0; i_psum_use = 1'b0;
        i_acc_len = '0; i_val = 1'b0; i_psum_rdy = 1'b1;
        #2;
        doReset(3);

        // 1: single-beat window, 1*2+2*2+3*2 = 12 per kernel, valid three cycles after acceptance
        applyStimulus(packData(1, 2, 3), weightAll(2), '0, 1'b0, CW'(1));
        waitResult("t1", lit4(12, 12, 12, 12), 1'b1);
        @(negedge clk);
        checkOutput("t1_single_pulse", o_psum_val, 1'b0);
        drainCheck("t1");

        // 2: nine beats seeded with 100; later beats carry junk len/use that must be ignored
        for (int b = 0; b < 9; b++)
            applyStimulus(packData(1, 1, 1), weightKplus1(), lit4(100, 100, 100, 100), 1'b1,
                          (b == 0) ? CW'(9) : CW'(3));
        waitResult("t2", lit4(127, 154, 181, 208), 1'b1);
        drainCheck("t2");

        // 3: backpressure with i_val held high; result must hold for five stall cycles
        r0 = resultsSeen;
        i_psum_rdy = 1'b0;
        fork
            begin
                applyStimulus(packData(1, 2, 3), weightAll(1), '0, 1'b0, CW'(1));
                applyStimulus(packData(5, -3, 7), weightKplus1(), '0, 1'b0, CW'(1));
                applyStimulus(packData(-9, 4, 2), weightAll(-5), lit4(7, 8, 9, 10), 1'b1, CW'(1));
                applyStimulus(packData(20, 30, -40), weightKplus1(), '0, 1'b0, CW'(1));
            end
            begin
                int g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!o_psum_val && g < 50);
                checkOutput("t3_valid_seen", o_psum_val, 1'b1);
                held = o_psum;
                checkOutput("t3_first_value", held, lit4(6, 6, 6, 6));
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("t3_rdy_low", o_rdy, 1'b0);
                    checkOutput("t3_hold", o_psum, held);
                end
                @(posedge clk);
                #1;
                i_psum_rdy = 1'b1;
            end
        join
        drainCheck("t3");
        checkOutput("t3_no_beat_lost", resultsSeen - r0, 4);

        // 4: saturation high, low, and continuing from the clamped value
        for (int b = 0; b < 4; b++)
            applyStimulus(packData(127, 127, 127), weightAll(127),
                          lit4(8388000, 8388000, 8388000, 8388000), 1'b1, CW'(4));
        waitResult("t4_hi", lit4(8388607, 8388607, 8388607, 8388607), 1'b0);
        applyStimulus(packData(-128, -128, -128), weightAll(127),
                      lit4(-8388000, -8388000, -8388000, -8388000), 1'b1, CW'(1));
        waitResult("t4_lo", lit4(-8388608, -8388608, -8388608, -8388608), 1'b0);
        applyStimulus(packData(127, 127, 127), weightAll(127),
                      lit4(8388607, 8388607, 8388607, 8388607), 1'b1, CW'(2));
        applyStimulus(packData(-1, -1, -1), weightAll(127), '0, 1'b0, CW'(2));
        waitResult("t4_resume", lit4(8388226, 8388226, 8388226, 8388226), 1'b0);
        drainCheck("t4");

        // 5: reset after beat 4 of 9 discards the window
        for (int b = 0; b < 4; b++)
            applyStimulus(packData(3, 3, 3), weightAll(3), lit4(50, 50, 50, 50), 1'b1, CW'(9));
        @(negedge clk);
        checkOutput("t5_busy_mid", o_busy, 1'b1);
        @(posedge clk);
        #1;
        doReset(2);
        applyStimulus(packData(1, 2, 3), weightAll(2), '0, 1'b0, CW'(1));
        waitResult("t5_clean", lit4(12, 12, 12, 12), 1'b1);
        drainCheck("t5");

        // 6: length-2 windows with gaps, back-to-back, then length 0 treated as 1
        r0 = resultsSeen;
        applyStimulus(packData(1, 1, 1), weightKplus1(), '0, 1'b0, CW'(2));
        idleCycles(3);
        applyStimulus(packData(1, 1, 1), weightKplus1(), '0, 1'b0, CW'(2));
        applyStimulus(packData(2, 0, -1), weightAll(3), '0, 1'b0, CW'(2));
        idleCycles(2);
        applyStimulus(packData(2, 0, -1), weightAll(3), '0, 1'b0, CW'(2));
        drainCheck("t6_pair");
        checkOutput("t6_two_results", resultsSeen - r0, 2);
        applyStimulus(packData(1, 2, 3), weightAll(1), '0, 1'b0, CW'(0));
        waitResult("t6_len0", lit4(6, 6, 6, 6), 1'b1);
        drainCheck("t6");

        // Randomised windows, seeds, gaps and downstream backpressure
        randRdy = 1'b1;
        for (int a = 0; a < 80; a++) begin
            int len;
            int beats;
            len   = $urandom_range(0, 6);
            beats = (len == 0) ? 1 : len;
            for (int b = 0; b < beats; b++) begin
                applyStimulus(DW'($urandom), {$urandom, $urandom, $urandom}, randSeed(),
                              1'($urandom_range(0, 1)), (b == 0) ? CW'(len) : CW'($urandom_range(0, 9)));
                if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
            end
        end
        randRdy = 1'b0;
        @(posedge clk);
        #2;
        i_psum_rdy = 1'b1;
        @(posedge clk);
        #1;
        drainCheck("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
